// File: rtl/demux1to4_stream.sv
// demux1to4_stream: 1-to-4 stream demultiplexer with valid/ready handshakes.
// Each accepted input word goes to the channel named by in_sel. Every channel
// has its own one-entry output register, so a stalled consumer blocks only
// words addressed to its own channel.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     producer offers in_data/in_sel
//   in_ready     word is accepted this cycle (depends only on selected channel)
//   in_data      word to route (WIDTH bits)
//   in_sel       destination channel 0..3
//   out_valid[k] channel k holds a word
//   out_ready[k] consumer k takes the word this cycle
//   out_data     channel k data on bits [k*WIDTH +: WIDTH]

// One output channel: a full flag plus a data register.
module demux1to4_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    // A load wins over a drain: on a simultaneous drain+load the old word
    // leaves and the new one takes its place, so full stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

module demux1to4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data
);

    logic [3:0] full;
    logic       accept;

    // Ready looks only at the selected channel; it may accept into a full
    // channel when that channel drains in the same cycle. Gating with rst_n
    // keeps the handshake closed while reset is asserted.
    assign in_ready  = rst_n && (!full[in_sel] || out_ready[in_sel]);
    assign accept    = in_valid && in_ready;
    assign out_valid = full;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        logic load;
        assign load = accept && (in_sel == 2'(k));

        demux1to4_chan #(.WIDTH(WIDTH)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .drain (out_ready[k]),
            .din   (in_data),
            .full  (full[k]),
            .dout  (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_demux1to4_stream.sv
module tb_demux1to4_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;

    int total = 0;
    int bad   = 0;

    // Per-channel expected contents (oldest first) and a log of words drained
    // from channel 0.
    logic [7:0] q [4][$];
    logic [7:0] log0 [$];

    demux1to4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard step, called at a negedge: drive inputs, compare outputs with
    // the model just before the rising edge, retire drained words, push the
    // accepted word, then move on to the next negedge.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] r);
        logic       exp_rdy;
        logic [7:0] w;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid[k] !== (q[k].size() != 0)) begin
                bad++;
                $display("FAIL sb_out_valid[%0d] got=%b exp=%b", k, out_valid[k], q[k].size() != 0);
            end
            if (q[k].size() != 0) begin
                total++;
                if (out_data[k*8 +: 8] !== q[k][0]) begin
                    bad++;
                    $display("FAIL sb_out_data[%0d] got=%h exp=%h", k, out_data[k*8 +: 8], q[k][0]);
                end
            end
        end
        exp_rdy = (q[s].size() == 0) || r[s];
        total++;
        if (in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL sb_in_ready sel=%0d got=%b exp=%b", s, in_ready, exp_rdy);
        end
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() != 0 && r[k]) begin
                w = q[k].pop_front();
                if (k == 0) log0.push_back(w);
            end
        end
        if (v && exp_rdy) q[s].push_back(d);
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) q[k].delete();
        log0.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_initial got v=%b d=%h r=%b exp v=0000 d=0 r=0",
                     out_valid, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_release_ready sel=%0d got=%b exp=1", s, in_ready);
            end
        end
        @(negedge clk);
        // Fill all four channels, then hit reset mid-stream.
        for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), 8'(8'hC0 + k), 4'b0000);
        total++;
        if (out_valid !== 4'b1111 || out_data !== 32'hC3C2C1C0) begin
            bad++;
            $display("FAIL reset_prefill got v=%b d=%h exp v=1111 d=c3c2c1c0", out_valid, out_data);
        end
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 8'hEE;
        out_ready = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got v=%b d=%h r=%b exp v=0000 d=0 r=0",
                     out_valid, out_data, in_ready);
        end
        clear_model();
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_no_accept got v=%b d=%h exp v=0000 d=0", out_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_rerelease_ready sel=%0d got=%b exp=1", s, in_ready);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_routing();
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 2'(k), words[k], 4'b1111);
            // One edge after acceptance the word sits on its own channel.
            #1;
            total++;
            if (out_valid[k] !== 1'b1 || out_data[k*8 +: 8] !== words[k]) begin
                bad++;
                $display("FAIL routing ch%0d got v=%b d=%h exp v=1 d=%h",
                         k, out_valid[k], out_data[k*8 +: 8], words[k]);
            end
        end
        cycle(1'b0, 2'd0, 8'h00, 4'b1111);
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL routing_drained got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_stall_isolation();
        cycle(1'b1, 2'd2, 8'hA5, 4'b1011);
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5A; out_ready = 4'b1011;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_data[23:16] !== 8'hA5) begin
            bad++;
            $display("FAIL stall_block got r=%b d2=%h exp r=0 d2=a5", in_ready, out_data[23:16]);
        end
        cycle(1'b1, 2'd2, 8'h5A, 4'b1011);
        cycle(1'b1, 2'd1, 8'h77, 4'b1011);
        total++;
        if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h77 || out_data[23:16] !== 8'hA5) begin
            bad++;
            $display("FAIL stall_other got v1=%b d1=%h d2=%h exp v1=1 d1=77 d2=a5",
                     out_valid[1], out_data[15:8], out_data[23:16]);
        end
        // Releasing the consumer lets the blocked word in on the same edge.
        cycle(1'b1, 2'd2, 8'h5A, 4'b1111);
        total++;
        if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h5A) begin
            bad++;
            $display("FAIL stall_release got v2=%b d2=%h exp v2=1 d2=5a", out_valid[2], out_data[23:16]);
        end
        cycle(1'b0, 2'd0, 8'h00, 4'b1111);
    endtask

    task automatic test_back_to_back();
        log0.delete();
        for (int i = 1; i <= 16; i++) cycle(1'b1, 2'd0, 8'(i), 4'b1111);
        cycle(1'b0, 2'd0, 8'h00, 4'b1111);
        total++;
        if (log0.size() != 16) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=16", log0.size());
        end
        for (int i = 0; i < 16 && i < log0.size(); i++) begin
            total++;
            if (log0[i] !== 8'(i + 1)) begin
                bad++;
                $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, log0[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_soak();
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom), 4'($urandom));
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 2'd0, 8'h00, 4'b1111);
        total++;
        if (out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL soak_final_empty got=%b exp=0000", out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sel = 2'd0;
        in_data = 8'h00;
        out_ready = 4'b0000;
        test_reset();
        test_routing();
        test_stall_isolation();
        test_back_to_back();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
